// File: rtl/alu.sv
// alu: 8-bit registered ALU, 4-bit opcode, tri-state result bus, c/o/s/z flags.
// Ports: clk, rst_n, en, oe, opcode[3:0], a[7:0], b[7:0] -> alu_out[7:0] (Z when oe=0), cf, of, sf, zf.
// Build option: ALU_SAT_EN makes ADD/INC saturate at 8'hFF and SUB/DEC at 8'h00.
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       oe,
  input  logic [3:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] alu_out,
  output logic       cf,
  output logic       of,
  output logic       sf,
  output logic       zf
);

  logic [7:0] res_q, res_d;
  logic       cf_q, cf_d;
  logic       of_q, of_d;
  logic       sf_q, sf_d;
  logic       zf_q, zf_d;

  logic [8:0] sum, diff, inc, dec;
  logic       add_of, sub_of;
  logic [7:0] add_r, sub_r, inc_r, dec_r;

  logic [7:0] r;
  logic       c, o, wr, ld;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign inc  = {1'b0, a} + 9'd1;
  assign dec  = {1'b0, a} - 9'd1;

  assign add_of = (a[7] == b[7]) && (sum[7] != a[7]);
  assign sub_of = (a[7] != b[7]) && (diff[7] != a[7]);

`ifdef ALU_SAT_EN
  // Flags keep the raw carry/borrow; only the value clamps.
  assign add_r = sum[8]  ? 8'hFF : sum[7:0];
  assign sub_r = diff[8] ? 8'h00 : diff[7:0];
  assign inc_r = inc[8]  ? 8'hFF : inc[7:0];
  assign dec_r = dec[8]  ? 8'h00 : dec[7:0];
`else
  assign add_r = sum[7:0];
  assign sub_r = diff[7:0];
  assign inc_r = inc[7:0];
  assign dec_r = dec[7:0];
`endif

  always_comb begin
    res_d = res_q;
    cf_d  = cf_q;
    of_d  = of_q;
    sf_d  = sf_q;
    zf_d  = zf_q;
    r     = 8'h00;
    c     = 1'b0;
    o     = 1'b0;
    wr    = 1'b1;
    ld    = 1'b1;
    unique case (opcode)
      4'h0: begin
        wr = 1'b0;
        ld = 1'b0;
      end
      4'h1: r = a;
      4'h2: begin
        r = add_r;
        c = sum[8];
        o = add_of;
      end
      4'h3: begin
        r = sub_r;
        c = diff[8];
        o = sub_of;
      end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: begin
        r = inc_r;
        c = inc[8];
        o = (a == 8'h7F);
      end
      4'h9: begin
        r = dec_r;
        c = dec[8];
        o = (a == 8'h80);
      end
      4'hA: begin
        r = {a[6:0], 1'b0};
        c = a[7];
      end
      4'hB: begin
        r = {1'b0, a[7:1]};
        c = a[0];
      end
      4'hC: begin
        r = {a[7], a[7:1]};
        c = a[0];
      end
      4'hD: begin
        r = {a[6:0], a[7]};
        c = a[7];
      end
      4'hE: begin
        r = {a[0], a[7:1]};
        c = a[0];
      end
      4'hF: begin
        // Compare: flags from a-b, result register untouched.
        r  = diff[7:0];
        c  = diff[8];
        o  = sub_of;
        wr = 1'b0;
      end
      default: begin
        wr = 1'b0;
        ld = 1'b0;
      end
    endcase
    if (ld) begin
      if (wr) res_d = r;
      cf_d = c;
      of_d = o;
      sf_d = r[7];
      zf_d = (r == 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= 8'h00;
      cf_q  <= 1'b0;
      of_q  <= 1'b0;
      sf_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else if (en) begin
      res_q <= res_d;
      cf_q  <= cf_d;
      of_q  <= of_d;
      sf_q  <= sf_d;
      zf_q  <= zf_d;
    end
  end

  assign alu_out = oe ? res_q : 8'hzz;
  assign cf = cf_q;
  assign of = of_q;
  assign sf = sf_q;
  assign zf = zf_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu; stimulus queues expectations,
// monitors pop and compare them when the output is due.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       oe;
  logic [3:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  // Pulled-up bus: an undriven (Z) alu_out reads back as 8'hFF.
  tri1  [7:0] bus;
  logic       cf, of, sf, zf;

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .oe     (oe),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .alu_out(bus),
    .cf     (cf),
    .of     (of),
    .sf     (sf),
    .zf     (zf)
  );

  typedef struct {
    string      nm;
    logic [7:0] bus;
    logic [3:0] fl;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_now;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drain();
    exp_t       e;
    logic [11:0] got;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e   = q.pop_front();
      got = {bus, cf, of, sf, zf};
      n_cmp++;
      if (got !== {e.bus, e.fl}) begin
        n_bad++;
        $display("FAIL %s: got bus=%h cosz=%b, want bus=%h cosz=%b",
                 e.nm, got[11:4], got[3:0], e.bus, e.fl);
      end
    end
  endtask

  // Clocked monitor: results are due one edge after issue.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    drain();
  end

  // Immediate monitor: for effects that need no clock edge.
  initial forever begin
    @(chk_now);
    #1;
    drain();
  end

  task automatic op(input logic [3:0] opc, input logic [7:0] av,
                    input logic [7:0] bv, input logic e, input logic o,
                    input logic [7:0] xb, input logic [3:0] xf,
                    input string nm);
    exp_t x;
    @(negedge clk);
    opcode = opc;
    a = av;
    b = bv;
    en = e;
    oe = o;
    x.nm = nm;
    x.bus = xb;
    x.fl = xf;
    x.due = cyc + 1;
    q.push_back(x);
  endtask

  task automatic imm(input logic [7:0] xb, input logic [3:0] xf,
                     input string nm);
    exp_t x;
    x.nm = nm;
    x.bus = xb;
    x.fl = xf;
    x.due = cyc;
    q.push_back(x);
    -> chk_now;
  endtask

  logic [7:0] sw [24];
  logic [7:0] r;
  logic       c;

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    oe = 1'b1;
    opcode = 4'h0;
    a = 8'h00;
    b = 8'h00;
`ifdef ALU_SAT_EN
    sw = '{8'h00, 8'h01, 8'h01, 8'h02,
           8'h00, 8'h00, 8'h01, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h01,
           8'h00, 8'h01, 8'h01, 8'h01,
           8'h00, 8'h01, 8'h01, 8'h00,
           8'hFF, 8'hFF, 8'hFE, 8'hFE};
`else
    sw = '{8'h00, 8'h01, 8'h01, 8'h02,
           8'h00, 8'hFF, 8'h01, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h01,
           8'h00, 8'h01, 8'h01, 8'h01,
           8'h00, 8'h01, 8'h01, 8'h00,
           8'hFF, 8'hFF, 8'hFE, 8'hFE};
`endif
    @(negedge clk);
    rst_n = 1'b1;

    op(4'h2, 8'h40, 8'h40, 1, 1, 8'h80, 4'b0110, "add_40_40");

    // Async reset mid-operation with a pending PASS.
    @(negedge clk);
    opcode = 4'h1;
    a = 8'h55;
    en = 1'b1;
    rst_n = 1'b0;
    imm(8'h00, 4'b0000, "async_reset");
    #2;
    en = 1'b0;
    rst_n = 1'b1;

    op(4'h2, 8'h01, 8'h01, 1, 1, 8'h02, 4'b0000, "add_1_1");
    op(4'h2, 8'h7F, 8'h01, 1, 1, 8'h80, 4'b0110, "add_7f_1");
`ifdef ALU_SAT_EN
    op(4'h2, 8'hFF, 8'h01, 1, 1, 8'hFF, 4'b1010, "add_ff_1");
    op(4'h3, 8'h00, 8'h01, 1, 1, 8'h00, 4'b1001, "sub_0_1");
    op(4'hF, 8'h05, 8'h05, 1, 1, 8'h00, 4'b0001, "cmp_5_5");
`else
    op(4'h2, 8'hFF, 8'h01, 1, 1, 8'h00, 4'b1001, "add_ff_1");
    op(4'h3, 8'h00, 8'h01, 1, 1, 8'hFF, 4'b1010, "sub_0_1");
    op(4'hF, 8'h05, 8'h05, 1, 1, 8'hFF, 4'b0001, "cmp_5_5");
`endif
    op(4'h8, 8'h7F, 8'h00, 1, 1, 8'h80, 4'b0110, "inc_7f");
`ifdef ALU_SAT_EN
    op(4'h9, 8'h00, 8'h00, 1, 1, 8'h00, 4'b1001, "dec_0");
`else
    op(4'h9, 8'h00, 8'h00, 1, 1, 8'hFF, 4'b1010, "dec_0");
`endif
    op(4'h9, 8'h80, 8'h00, 1, 1, 8'h7F, 4'b0100, "dec_80");
    op(4'h3, 8'h80, 8'h01, 1, 1, 8'h7F, 4'b0100, "sub_80_1");
    op(4'hA, 8'hC1, 8'h00, 1, 1, 8'h82, 4'b1010, "shl_c1");
    op(4'hB, 8'h81, 8'h00, 1, 1, 8'h40, 4'b1000, "shr_81");
    op(4'hC, 8'h81, 8'h00, 1, 1, 8'hC0, 4'b1010, "asr_81");
    op(4'h0, 8'h12, 8'h34, 1, 1, 8'hC0, 4'b1010, "nop_hold");
    op(4'hE, 8'h01, 8'h00, 1, 1, 8'h80, 4'b1010, "ror_01");
    op(4'h1, 8'h00, 8'hFF, 1, 1, 8'h00, 4'b0001, "pass_0");

    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 6; k++) begin
        for (int j = 0; j < 4; j++) begin
          r = sw[k*4+j];
          c = (k == 1 && j == 1);
          op(4'(k + 2), 8'(j >> 1), 8'(j & 1), 1'b1, pass == 0,
             (pass == 0) ? r : 8'hFF, {c, 1'b0, r[7], r == 8'h00},
             (pass == 0) ? "sweep_oe1" : "sweep_oe0");
        end
      end
    end

    // Raise oe with no clock edge: last result (NOT 1 = FE) appears.
    @(negedge clk);
    en = 1'b0;
    oe = 1'b1;
    imm(8'hFE, 4'b0010, "oe_raise");

    op(4'h2, 8'hFF, 8'h01, 0, 1, 8'hFE, 4'b0010, "en0_add");
    op(4'hA, 8'h80, 8'h00, 0, 1, 8'hFE, 4'b0010, "en0_shl");
    op(4'h9, 8'h00, 8'h00, 0, 1, 8'hFE, 4'b0010, "en0_dec");
    op(4'hD, 8'h81, 8'h00, 1, 1, 8'h03, 4'b1000, "rol_81");
    op(4'h0, 8'h00, 8'h00, 1, 0, 8'hFF, 4'b1000, "oe0_hiz");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
